// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcode constants, format enum and decoded-field struct for the decode stage
package decode_pkg;

   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_ILL = 3'd6
   } fmt_e;

   // Width-independent fields; pc and imm are attached by the stage at their parameterised widths.
   typedef struct packed {
      logic [6:0] opcode;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [2:0] funct3;
      logic [6:0] funct7;
      fmt_e       fmt;
      logic       illegal;
   } decoded_t;

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-side and consumer-side handshake bundle of the decode stage
interface decode_stage_if
   import decode_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int PC_W = 32
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_ins;
   logic [PC_W-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [PC_W-1:0] out_pc;
   logic [6:0]      out_opcode;
   logic [4:0]      out_rd;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [2:0]      out_funct3;
   logic [6:0]      out_funct7;
   fmt_e            out_fmt;
   logic [XLEN-1:0] out_imm;
   logic            out_illegal;

   modport master (
      output flush, in_valid, in_ins, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
             out_funct3, out_funct7, out_fmt, out_imm, out_illegal
   );

   modport slave (
      input  flush, in_valid, in_ins, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
             out_funct3, out_funct7, out_fmt, out_imm, out_illegal
   );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// rtl/decode_stage_imm_gen.sv - combinational immediate builder, sign-extended to XLEN
module imm_gen
   import decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:7]     ins,
   input  fmt_e            fmt,
   output logic [XLEN-1:0] imm
);
   logic        s;
   logic [31:0] imm32;

   assign s = ins[31];

   always_comb begin
      imm32 = '0;
      case (fmt)
         FMT_I:   imm32 = {{20{s}}, ins[31:20]};
         FMT_S:   imm32 = {{20{s}}, ins[31:25], ins[11:7]};
         FMT_B:   imm32 = {{19{s}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         FMT_J:   imm32 = {{11{s}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         FMT_U:   imm32 = {ins[31:12], 12'b0};
         default: imm32 = '0;
      endcase
   end

   assign imm = XLEN'($signed(imm32));
endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I/RV64I decode: field split, format, immediate, illegal check,
// head register plus optional skid entry behind a valid/ready handshake
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int PC_W    = 32,
   parameter int M_EXT   = 0,
   parameter int SKID_EN = 1
) (
   input logic           clk,
   input logic           rst_n,
   decode_stage_if.slave bus
);
   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [XLEN-1:0] imm;
      decoded_t        f;
   } entry_t;

   logic [31:0]     ins;
   logic [6:0]      opc;
   logic [2:0]      f3;
   logic [6:0]      f7;
   fmt_e            fmt_raw;
   fmt_e            fmt;
   logic            bad;
   logic [XLEN-1:0] imm;
   entry_t          new_e;

   entry_t head_q, head_d, skid_q, skid_d;
   logic   head_valid_q, head_valid_d, skid_valid_q, skid_valid_d;
   logic   push, pop;

   assign ins = bus.in_ins;
   assign opc = ins[6:0];
   assign f3  = ins[14:12];
   assign f7  = ins[31:25];

   always_comb begin
      fmt_raw = FMT_ILL;
      case (opc)
         OPC_LUI, OPC_AUIPC: fmt_raw = FMT_U;
         OPC_JAL:            fmt_raw = FMT_J;
         OPC_BRANCH:         fmt_raw = FMT_B;
         OPC_STORE:          fmt_raw = FMT_S;
         OPC_OP:             fmt_raw = FMT_R;
         OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM: fmt_raw = FMT_I;
         OPC_OP_IMM_32:      fmt_raw = (XLEN == 64) ? FMT_I : FMT_ILL;
         OPC_OP_32:          fmt_raw = (XLEN == 64) ? FMT_R : FMT_ILL;
         default:            fmt_raw = FMT_ILL;
      endcase
   end

   always_comb begin
      bad = (ins[1:0] != 2'b11) || (fmt_raw == FMT_ILL);
      case (opc)
         OPC_BRANCH: if (f3 == 3'b010 || f3 == 3'b011) bad = 1'b1;
         OPC_JALR:   if (f3 != 3'b000) bad = 1'b1;
         OPC_LOAD:   if (f3 == 3'b111 || (XLEN == 32 && (f3 == 3'b011 || f3 == 3'b110))) bad = 1'b1;
         OPC_STORE:  if (f3 > ((XLEN == 32) ? 3'd2 : 3'd3)) bad = 1'b1;
         OPC_OP_IMM: begin
            // shamt[5] lives in funct7[0], which only exists on RV64
            if (f3 == 3'b001 && f7[6:1] != 6'b000000) bad = 1'b1;
            if (f3 == 3'b101 && f7[6:1] != 6'b000000 && f7[6:1] != 6'b010000) bad = 1'b1;
            if (XLEN == 32 && f3[1:0] == 2'b01 && f7[0]) bad = 1'b1;
         end
         OPC_OP: begin
            if (!(f7 == 7'b0000000 ||
                  (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) ||
                  (f7 == 7'b0000001 && M_EXT != 0))) bad = 1'b1;
         end
         default: ;
      endcase
   end

   assign fmt = bad ? FMT_ILL : fmt_raw;

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .ins (ins[31:7]),
      .fmt (fmt),
      .imm (imm)
   );

   always_comb begin
      new_e          = '0;
      new_e.pc       = bus.in_pc;
      new_e.imm      = imm;
      new_e.f.opcode = opc;
      new_e.f.rd     = (fmt == FMT_S || fmt == FMT_B) ? 5'd0 : ins[11:7];
      new_e.f.rs1    = (fmt == FMT_U || fmt == FMT_J) ? 5'd0 : ins[19:15];
      new_e.f.rs2    = (fmt == FMT_I || fmt == FMT_U || fmt == FMT_J) ? 5'd0 : ins[24:20];
      new_e.f.funct3 = f3;
      new_e.f.funct7 = f7;
      new_e.f.fmt    = fmt;
      new_e.f.illegal = bad;
   end

   assign bus.in_ready = (SKID_EN != 0) ? !skid_valid_q : (!head_valid_q || bus.out_ready);
   assign push = bus.in_valid && bus.in_ready;
   assign pop  = head_valid_q && bus.out_ready;

   always_comb begin
      head_d       = head_q;
      head_valid_d = head_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (bus.flush) begin
         head_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (SKID_EN != 0) begin
         // in_ready is low whenever skid is occupied, so pop-with-skid never sees a push
         if (pop) begin
            if (skid_valid_q) begin
               head_d       = skid_q;
               skid_valid_d = 1'b0;
            end else if (push) begin
               head_d = new_e;
            end else begin
               head_valid_d = 1'b0;
            end
         end else if (push) begin
            if (head_valid_q) begin
               skid_d       = new_e;
               skid_valid_d = 1'b1;
            end else begin
               head_d       = new_e;
               head_valid_d = 1'b1;
            end
         end
      end else begin
         if (push) begin
            head_d       = new_e;
            head_valid_d = 1'b1;
         end else if (pop) begin
            head_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q       <= '0;
         skid_q       <= '0;
         head_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         head_q       <= head_d;
         skid_q       <= skid_d;
         head_valid_q <= head_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign bus.out_valid   = head_valid_q;
   assign bus.out_pc      = head_q.pc;
   assign bus.out_imm     = head_q.imm;
   assign bus.out_opcode  = head_q.f.opcode;
   assign bus.out_rd      = head_q.f.rd;
   assign bus.out_rs1     = head_q.f.rs1;
   assign bus.out_rs2     = head_q.f.rs2;
   assign bus.out_funct3  = head_q.f.funct3;
   assign bus.out_funct7  = head_q.f.funct7;
   assign bus.out_fmt     = head_q.f.fmt;
   assign bus.out_illegal = head_q.f.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed-vector bench for decode_stage at RV32 (M_EXT=0) and RV64 (M_EXT=1)
module tb_decode_stage;
   import decode_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   decode_stage_if #(.XLEN(32), .PC_W(32)) if32();
   decode_stage_if #(.XLEN(64), .PC_W(32)) if64();

   decode_stage #(.XLEN(32), .PC_W(32), .M_EXT(0), .SKID_EN(1)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
   decode_stage #(.XLEN(64), .PC_W(32), .M_EXT(1), .SKID_EN(1)) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy, input logic fl);
      if32.in_valid = v;   if64.in_valid = v;
      if32.in_ins = ins;   if64.in_ins = ins;
      if32.in_pc = pc;     if64.in_pc = pc;
      if32.out_ready = rdy; if64.out_ready = rdy;
      if32.flush = fl;     if64.flush = fl;
   endtask

   typedef struct {
      logic [31:0] ins;
      logic [2:0]  f32;
      logic [31:0] i32;
      logic        il32;
      logic [2:0]  f64;
      logic [63:0] i64;
      logic        il64;
      logic        regs;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
   } vec_t;

   vec_t vecs[11] = '{
      '{32'hFFF00093, 3'd1, 32'hFFFFFFFF, 1'b0, 3'd1, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b1, 5'd1, 5'd0, 5'd0},
      '{32'h0020A423, 3'd2, 32'h00000008, 1'b0, 3'd2, 64'h00000000_00000008, 1'b0, 1'b1, 5'd0, 5'd1, 5'd2},
      '{32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 1'b0, 3'd3, 64'hFFFFFFFF_FFFFFFFC, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0},
      '{32'h001000EF, 3'd5, 32'h00000800, 1'b0, 3'd5, 64'h00000000_00000800, 1'b0, 1'b1, 5'd1, 5'd0, 5'd0},
      '{32'h123452B7, 3'd4, 32'h12345000, 1'b0, 3'd4, 64'h00000000_12345000, 1'b0, 1'b1, 5'd5, 5'd0, 5'd0},
      '{32'h800002B7, 3'd4, 32'h80000000, 1'b0, 3'd4, 64'hFFFFFFFF_80000000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0},
      '{32'h00000000, 3'd6, 32'h00000000, 1'b1, 3'd6, 64'h0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0},
      '{32'h0000207F, 3'd6, 32'h00000000, 1'b1, 3'd6, 64'h0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0},
      '{32'h40001033, 3'd6, 32'h00000000, 1'b1, 3'd6, 64'h0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0},
      '{32'h02000033, 3'd6, 32'h00000000, 1'b1, 3'd0, 64'h0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0},
      '{32'h0010809B, 3'd6, 32'h00000000, 1'b1, 3'd1, 64'h00000000_00000001, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0}
   };

   logic [31:0] got_q[$];
   int          cyc_q[$];
   logic [31:0] bp_pc[3] = '{32'h2000, 32'h2004, 32'h2008};

   initial begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      check_eq("rst_out_valid", 64'(if32.out_valid), 64'(0));
      check_eq("rst_in_ready", 64'(if32.in_ready), 64'(1));
      check_eq("rst_out_imm", 64'(if64.out_imm), 64'(0));
      check_eq("rst_out_pc", 64'(if32.out_pc), 64'(0));
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         drive(1'b1, vecs[i].ins, 32'h1000 + 32'(4 * i), 1'b1, 1'b0);
         #1;
         check_eq($sformatf("v%0d_pre_valid", i), 64'(if32.out_valid), 64'(0));
         check_eq($sformatf("v%0d_in_ready", i), 64'(if32.in_ready), 64'(1));
         @(negedge clk);
         drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
         check_eq($sformatf("v%0d_valid32", i), 64'(if32.out_valid), 64'(1));
         check_eq($sformatf("v%0d_valid64", i), 64'(if64.out_valid), 64'(1));
         check_eq($sformatf("v%0d_pc", i), 64'(if32.out_pc), 64'(32'h1000 + 32'(4 * i)));
         check_eq($sformatf("v%0d_fmt32", i), 64'(if32.out_fmt), 64'(vecs[i].f32));
         check_eq($sformatf("v%0d_imm32", i), 64'(if32.out_imm), 64'(vecs[i].i32));
         check_eq($sformatf("v%0d_ill32", i), 64'(if32.out_illegal), 64'(vecs[i].il32));
         check_eq($sformatf("v%0d_fmt64", i), 64'(if64.out_fmt), 64'(vecs[i].f64));
         check_eq($sformatf("v%0d_imm64", i), if64.out_imm, vecs[i].i64);
         check_eq($sformatf("v%0d_ill64", i), 64'(if64.out_illegal), 64'(vecs[i].il64));
         if (vecs[i].regs) begin
            check_eq($sformatf("v%0d_rd", i), 64'(if32.out_rd), 64'(vecs[i].rd));
            check_eq($sformatf("v%0d_rs1", i), 64'(if32.out_rs1), 64'(vecs[i].rs1));
            check_eq($sformatf("v%0d_rs2", i), 64'(if32.out_rs2), 64'(vecs[i].rs2));
         end
      end

      // Backpressure: A, B fill head and skid; C waits at the input.
      @(negedge clk);
      drive(1'b1, 32'hFFF00093, 32'h2000, 1'b0, 1'b0);
      @(negedge clk);
      check_eq("bp_ready_one", 64'(if32.in_ready), 64'(1));
      drive(1'b1, 32'h0020A423, 32'h2004, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 32'hFE000EE3, 32'h2008, 1'b0, 1'b0);
      check_eq("bp_ready_full", 64'(if32.in_ready), 64'(0));
      check_eq("bp_head", 64'(if32.out_pc), 64'(32'h2000));
      @(negedge clk);
      check_eq("bp_ready_hold", 64'(if32.in_ready), 64'(0));
      check_eq("bp_head_stable", 64'(if32.out_pc), 64'(32'h2000));
      check_eq("bp_head_imm_stable", 64'(if32.out_imm), 64'(32'hFFFFFFFF));
      drive(1'b1, 32'hFE000EE3, 32'h2008, 1'b1, 1'b0);
      #1;
      for (int cyc = 0; cyc < 8; cyc++) begin
         logic in_fire;
         if (if32.out_valid && if32.out_ready) begin
            got_q.push_back(if32.out_pc);
            cyc_q.push_back(cyc);
         end
         in_fire = if32.in_valid && if32.in_ready;
         @(posedge clk);
         #1;
         if (in_fire) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
         @(negedge clk);
      end
      check_eq("bp_count", 64'(got_q.size()), 64'(3));
      for (int k = 0; k < got_q.size() && k < 3; k++)
         check_eq($sformatf("bp_order%0d", k), 64'(got_q[k]), 64'(bp_pc[k]));
      if (cyc_q.size() >= 3)
         check_eq("bp_throughput", 64'(cyc_q[2] - cyc_q[0]), 64'(2));

      // Flush with two entries held and fetch still presenting.
      @(negedge clk);
      drive(1'b1, 32'hFFF00093, 32'h3000, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 32'h0020A423, 32'h3004, 1'b0, 1'b0);
      @(negedge clk);
      check_eq("fl_pre_valid", 64'(if32.out_valid), 64'(1));
      drive(1'b1, 32'hFE000EE3, 32'h3008, 1'b0, 1'b1);
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check_eq("fl_out_valid32", 64'(if32.out_valid), 64'(0));
      check_eq("fl_out_valid64", 64'(if64.out_valid), 64'(0));
      check_eq("fl_in_ready", 64'(if32.in_ready), 64'(1));
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_eq($sformatf("fl_nothing%0d", k), 64'(if32.out_valid), 64'(0));
      end
      // Flush in the same cycle an input is accepted into an empty stage.
      drive(1'b1, 32'h123452B7, 32'h3100, 1'b0, 1'b1);
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check_eq("fl_push_dropped", 64'(if32.out_valid), 64'(0));

      // Reset mid-stream.
      @(negedge clk);
      drive(1'b1, 32'h123452B7, 32'h4000, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 32'h0020A423, 32'h4004, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check_eq("mr_pre_valid", 64'(if32.out_valid), 64'(1));
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_eq("mr_out_valid", 64'(if32.out_valid), 64'(0));
      check_eq("mr_out_valid64", 64'(if64.out_valid), 64'(0));
      check_eq("mr_in_ready", 64'(if32.in_ready), 64'(1));
      check_eq("mr_out_pc", 64'(if32.out_pc), 64'(0));
      check_eq("mr_out_imm", 64'(if32.out_imm), 64'(0));
      check_eq("mr_out_rd", 64'(if32.out_rd), 64'(0));
      check_eq("mr_out_opcode", 64'(if32.out_opcode), 64'(0));
      check_eq("mr_out_funct3", 64'(if32.out_funct3), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
